// File: rtl/phase_timer.sv
// phase_timer: per-phase duration timer with prescaled ticks, pause, runtime durations and select-error flag.
// Defining PHASE_TIMER_FORCE_END_EN adds a force_end input that ends the active phase immediately.
module phase_timer #(
    parameter int NUM_PHASES = 3,
    parameter int CNT_W = 8,
    parameter int PRESCALE = 1,
    parameter logic [NUM_PHASES*CNT_W-1:0] DEF_DUR = {8'd4, 8'd2, 8'd3},
    parameter int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PHASES-1:0] phase_sel,
    input  logic                  pause,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [CNT_W-1:0]      cfg_dur,
`ifdef PHASE_TIMER_FORCE_END_EN
    input  logic                  force_end,
`endif
    output logic [NUM_PHASES-1:0] phase_end,
    output logic [CNT_W-1:0]      remaining,
    output logic                  sel_err
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
    localparam logic [IDX_W:0] NP = (IDX_W + 1)'(NUM_PHASES);

    logic [CNT_W-1:0] dur [NUM_PHASES];
    logic [CNT_W-1:0] elapsed, active_dur, cur_dur, load_dur;
    logic [PS_W-1:0] prescaler;
    logic [NUM_PHASES-1:0] prev_sel;
    logic [IDX_W-1:0] cur_idx;
    logic valid, restart, tick, expire, frc, cfg_hit;

`ifdef PHASE_TIMER_FORCE_END_EN
    assign frc = force_end;
`else
    assign frc = 1'b0;
`endif

    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < NUM_PHASES; i++)
            if (phase_sel[i]) cur_idx = IDX_W'(i);
    end

    assign valid = (phase_sel != '0) && ((phase_sel & (phase_sel - 1'b1)) == '0);
    assign sel_err = ~valid;
    assign restart = valid && (phase_sel != prev_sel);
    assign tick = prescaler == PS_MAX;
    assign cfg_hit = cfg_we && ({1'b0, cfg_idx} < NP);
    // A write to the phase being (re)loaded this cycle is forwarded into the load.
    assign cur_dur = (cfg_we && cfg_idx == cur_idx) ? cfg_dur : dur[cur_idx];
    assign load_dur = (cur_dur == '0) ? CNT_W'(1) : cur_dur;
    assign expire = valid && !restart && (frc || (tick && !pause && elapsed == active_dur - 1'b1));
    assign phase_end = expire ? phase_sel : '0;
    assign remaining = valid ? active_dur - elapsed : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHASES; i++)
                dur[i] <= DEF_DUR[i*CNT_W +: CNT_W];
            elapsed <= '0;
            prescaler <= '0;
            active_dur <= '0;
            prev_sel <= '0;
        end else begin
            prev_sel <= phase_sel;
            if (cfg_hit) dur[cfg_idx] <= cfg_dur;
            if (!valid) begin
                elapsed <= '0;
                prescaler <= '0;
            end else if (restart || expire) begin
                elapsed <= '0;
                prescaler <= '0;
                active_dur <= load_dur;
            end else if (!pause) begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
                if (tick) elapsed <= elapsed + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_phase_timer.sv
// tb_phase_timer: randomized scoreboard bench for two phase_timer instances (PRESCALE 1 and 3).
module tb_phase_timer;
    typedef struct {
        logic [2:0] pe;
        logic [7:0] rem;
        logic       err;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, pause = 1'b0, cfg_we = 1'b0;
    logic [2:0] phase_sel = 3'b0;
    logic [1:0] cfg_idx = 2'b0;
    logic [7:0] cfg_dur = 8'b0;
    logic [2:0] pe0, pe1;
    logic [7:0] rem0, rem1;
    logic err0, err1;
    int checks = 0, errors = 0;
    exp_t q0[$], q1[$];
    int mdur[2][3], mlen[2], mleft[2], msub[2];
    logic [2:0] mprev[2];

    always #5 clk = ~clk;

    phase_timer #(.PRESCALE(1)) u0 (
        .clk(clk), .rst(rst), .phase_sel(phase_sel), .pause(pause), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_dur(cfg_dur), .phase_end(pe0), .remaining(rem0), .sel_err(err0)
    );
    phase_timer #(.PRESCALE(3)) u1 (
        .clk(clk), .rst(rst), .phase_sel(phase_sel), .pause(pause), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_dur(cfg_dur), .phase_end(pe1), .remaining(rem1), .sel_err(err1)
    );

    function automatic int ps(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit onehot(logic [2:0] s);
        return $countones(s) == 1;
    endfunction

    // Model: countdown of ticks left in the interval plus cycles spent in the current tick.
    function automatic exp_t expect_out(int k);
        exp_t e;
        bit v, rs, ex;
        v = onehot(phase_sel);
        rs = v && (phase_sel != mprev[k]);
        ex = v && !rs && !pause && (msub[k] == ps(k) - 1) && (mleft[k] == 1);
        e.pe = ex ? phase_sel : 3'b0;
        e.rem = v ? 8'(mleft[k]) : 8'd0;
        e.err = !v;
        return e;
    endfunction

    task automatic step(int k);
        exp_t e;
        int p;
        e = expect_out(k);
        if (rst) begin
            mdur[k][0] = 3;
            mdur[k][1] = 2;
            mdur[k][2] = 4;
            mlen[k] = 0;
            mleft[k] = 0;
            msub[k] = 0;
            mprev[k] = 3'b0;
        end else begin
            if (cfg_we && cfg_idx < 3) mdur[k][cfg_idx] = int'(cfg_dur);
            if (!onehot(phase_sel)) begin
                mleft[k] = mlen[k];
                msub[k] = 0;
            end else if (phase_sel != mprev[k] || e.pe != 3'b0) begin
                p = phase_sel[0] ? 0 : (phase_sel[1] ? 1 : 2);
                mlen[k] = (mdur[k][p] == 0) ? 1 : mdur[k][p];
                mleft[k] = mlen[k];
                msub[k] = 0;
            end else if (!pause) begin
                if (msub[k] == ps(k) - 1) begin
                    msub[k] = 0;
                    mleft[k] = mleft[k] - 1;
                end else begin
                    msub[k] = msub[k] + 1;
                end
            end
            mprev[k] = phase_sel;
        end
    endtask

    task automatic cmp(string nm, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
        end
    endtask

    task automatic drive(int c);
        if (c < 3) begin
            rst = 1'b1;
            phase_sel = 3'b0;
        end else if (c < 16) begin
            rst = 1'b0;
            phase_sel = 3'b001;
            pause = 1'b0;
            cfg_we = 1'b0;
        end else begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 24) == 0)
                phase_sel = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                        : 3'(1 << $urandom_range(0, 2));
            pause = ($urandom_range(0, 7) == 0);
            cfg_we = ($urandom_range(0, 9) == 0);
            cfg_idx = 2'($urandom_range(0, 3));
            cfg_dur = 8'($urandom_range(0, 6));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            cmp("u0.phase_end", int'(pe0), int'(e.pe));
            cmp("u0.remaining", int'(rem0), int'(e.rem));
            cmp("u0.sel_err", int'(err0), int'(e.err));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp("u1.phase_end", int'(pe1), int'(e.pe));
            cmp("u1.remaining", int'(rem1), int'(e.rem));
            cmp("u1.sel_err", int'(err1), int'(e.err));
        end
    end

    initial begin
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk);
            #1;
            step(0);
            step(1);
            drive(c);
            if (!rst) begin
                q0.push_back(expect_out(0));
                q1.push_back(expect_out(1));
            end
        end
        @(negedge clk);
        #1;
        cmp("queues_drained", q0.size() + q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
